// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - melody sequencer feeding the square-wave tone stage
//
// Steps through an 8-entry note ROM at a fixed tempo and presents one note
// at a time as a half-period reload value plus a gate.
//
// Ports:
//   CLK100MHZ  in   system clock, rising edge
//   RST        in   synchronous reset, active high
//   PLAY       in   level: high = play, low = stop
//   LOOP       in   level: restart at entry 0 after the last entry
//   NOTE_DIV   out  half-period reload for the tone stage (0 for a rest)
//   NOTE_EN    out  gate: 1 = tone stage drives audio
//   NOTE_STB   out  one-cycle pulse when a new ROM entry is presented
//   NOTE_IDX   out  ROM index currently presented
//   PLAYING    out  high while loading, sounding or in the inter-note gap
module note_sequencer #(
    parameter int CLK_HZ      = 100000000,
    parameter int TICK_CYCLES = 6250000,
    parameter int GAP_CYCLES  = 500000,
    parameter int DIV_WIDTH   = 20
) (
    input  logic                 CLK100MHZ,
    input  logic                 RST,
    input  logic                 PLAY,
    input  logic                 LOOP,
    output logic [DIV_WIDTH-1:0] NOTE_DIV,
    output logic                 NOTE_EN,
    output logic                 NOTE_STB,
    output logic [2:0]           NOTE_IDX,
    output logic                 PLAYING
);

    localparam int TICK_W = $clog2(TICK_CYCLES + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    // Reload = round(CLK_HZ / (2*f)) - 1; rounding to nearest keeps each
    // tone within half a clock of the ideal half period.
    function automatic int half_period(input int f);
        return (f == 0) ? 0 : (CLK_HZ + f) / (2 * f) - 1;
    endfunction

    localparam logic [DIV_WIDTH-1:0] DIV_TAB [0:15] = '{
        '0,
        DIV_WIDTH'(half_period(262)), DIV_WIDTH'(half_period(294)),
        DIV_WIDTH'(half_period(330)), DIV_WIDTH'(half_period(349)),
        DIV_WIDTH'(half_period(392)), DIV_WIDTH'(half_period(440)),
        DIV_WIDTH'(half_period(494)), DIV_WIDTH'(half_period(523)),
        '0, '0, '0, '0, '0, '0, '0
    };

    function automatic logic [3:0] rom_code(input logic [2:0] i);
        case (i)
            3'd0:    return 4'd1;
            3'd1:    return 4'd2;
            3'd2:    return 4'd3;
            3'd3:    return 4'd0;
            3'd4:    return 4'd5;
            3'd5:    return 4'd6;
            3'd6:    return 4'd7;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [2:0] rom_dur(input logic [2:0] i);
        return (i == 3'd7) ? 3'd4 : 3'd2;
    endfunction

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_NOTE, S_GAP, S_DONE} state_t;

    state_t               state, state_nxt;
    logic [2:0]           idx, idx_nxt;
    logic [3:0]           dur, dur_nxt;
    logic [TICK_W-1:0]    tick, tick_nxt;
    logic [GAP_W-1:0]     gap, gap_nxt;
    logic [DIV_WIDTH-1:0] div_nxt;
    logic                 en_nxt, stb_nxt, playing_nxt;
    logic [2:0]           nidx_nxt;
    logic [3:0]           code;
    logic [2:0]           rdur;

    assign code = rom_code(idx);
    assign rdur = rom_dur(idx);

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            state    <= S_IDLE;
            idx      <= '0;
            dur      <= '0;
            tick     <= '0;
            gap      <= '0;
            NOTE_DIV <= '0;
            NOTE_EN  <= 1'b0;
            NOTE_STB <= 1'b0;
            NOTE_IDX <= '0;
            PLAYING  <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            dur      <= dur_nxt;
            tick     <= tick_nxt;
            gap      <= gap_nxt;
            NOTE_DIV <= div_nxt;
            NOTE_EN  <= en_nxt;
            NOTE_STB <= stb_nxt;
            NOTE_IDX <= nidx_nxt;
            PLAYING  <= playing_nxt;
        end
    end

    // Stop (PLAY low) outranks tick/gap expiry in every active state.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (PLAY) state_nxt = S_LOAD;
            S_LOAD: state_nxt = PLAY ? S_NOTE : S_IDLE;
            S_NOTE: begin
                if (!PLAY)
                    state_nxt = S_IDLE;
                else if (tick == '0 && dur <= 4'd1)
                    state_nxt = S_GAP;
            end
            S_GAP: begin
                if (!PLAY)
                    state_nxt = S_IDLE;
                else if (gap == '0)
                    state_nxt = (idx != 3'd7 || LOOP) ? S_LOAD : S_DONE;
            end
            S_DONE: if (!PLAY) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        idx_nxt     = idx;
        dur_nxt     = dur;
        tick_nxt    = tick;
        gap_nxt     = gap;
        div_nxt     = NOTE_DIV;
        en_nxt      = NOTE_EN;
        nidx_nxt    = NOTE_IDX;
        stb_nxt     = 1'b0;
        playing_nxt = (state_nxt == S_LOAD) || (state_nxt == S_NOTE) ||
                      (state_nxt == S_GAP);
        case (state)
            S_IDLE: if (state_nxt == S_LOAD) idx_nxt = 3'd0;
            S_LOAD: begin
                if (state_nxt == S_NOTE) begin
                    div_nxt  = DIV_TAB[code];
                    en_nxt   = (code != 4'd0);
                    stb_nxt  = 1'b1;
                    nidx_nxt = idx;
                    dur_nxt  = (rdur == 3'd0) ? 4'd1 : {1'b0, rdur};
                    tick_nxt = TICK_W'(TICK_CYCLES - 1);
                end
            end
            S_NOTE: begin
                if (state_nxt == S_GAP) begin
                    en_nxt  = 1'b0;
                    gap_nxt = GAP_W'(GAP_CYCLES - 1);
                end else if (state_nxt == S_NOTE) begin
                    if (tick == '0) begin
                        tick_nxt = TICK_W'(TICK_CYCLES - 1);
                        dur_nxt  = dur - 4'd1;
                    end else begin
                        tick_nxt = tick - TICK_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (state_nxt == S_LOAD)
                    idx_nxt = (idx == 3'd7) ? 3'd0 : idx + 3'd1;
                else if (state_nxt == S_GAP)
                    gap_nxt = gap - GAP_W'(1);
            end
            default: ;
        endcase
        // Leaving the active states always silences the tone stage.
        if (state_nxt == S_IDLE || state_nxt == S_DONE)
            en_nxt = 1'b0;
    end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed-vector bench for note_sequencer
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        rst, play, loop;
    logic [19:0] note_div;
    logic        note_en, note_stb, playing;
    logic [2:0]  note_idx;

    int vec_cnt = 0;
    int err_cnt = 0;

    int exp_div[8]    = '{190839, 170067, 151514, 0, 127550, 113635, 101214, 95601};
    int exp_en_len[8] = '{20, 20, 20, 0, 20, 20, 20, 40};

    always #5 clk = ~clk;

    note_sequencer #(
        .CLK_HZ(100000000),
        .TICK_CYCLES(10),
        .GAP_CYCLES(2),
        .DIV_WIDTH(20)
    ) dut (
        .CLK100MHZ(clk),
        .RST(rst),
        .PLAY(play),
        .LOOP(loop),
        .NOTE_DIV(note_div),
        .NOTE_EN(note_en),
        .NOTE_STB(note_stb),
        .NOTE_IDX(note_idx),
        .PLAYING(playing)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Steps until a strobe for entry 'want' is seen; n = cycles taken, -1 on timeout.
    task automatic wait_stb(input int want, input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            step();
            if (note_stb && note_idx == 3'(want)) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_div"}, note_div, 0);
        check({tag, "_en"}, note_en, 0);
        check({tag, "_stb"}, note_stb, 0);
        check({tag, "_idx"}, note_idx, 0);
        check({tag, "_playing"}, playing, 0);
    endtask

    initial begin
        int cyc, stb_n, done_cyc, n, seen;
        int stb_t[8];
        int en_cnt[8];

        rst = 1'b1; play = 1'b1; loop = 1'b0;
        step();
        step();
        check_reset_vals("reset");

        // Release reset with PLAY held: IDLE -> LOAD -> first strobe.
        rst = 1'b0;
        step();
        check("load_no_stb", note_stb, 0);
        check("load_playing", playing, 1);
        step();
        check("first_stb", note_stb, 1);
        check("first_div", note_div, 190839);
        check("first_idx", note_idx, 0);
        check("first_en", note_en, 1);

        // Full melody with LOOP=0, timed from the first strobe.
        for (int i = 0; i < 8; i++) begin
            stb_t[i]  = -1;
            en_cnt[i] = 0;
        end
        stb_t[0] = 0; en_cnt[0] = 1; stb_n = 1; cyc = 0; done_cyc = -1;
        for (int k = 0; k < 300; k++) begin
            step();
            cyc++;
            if (note_stb) begin
                if (stb_n < 8) stb_t[stb_n] = cyc;
                check($sformatf("div_idx%0d", note_idx), note_div, exp_div[note_idx]);
                stb_n++;
            end
            if (note_en) en_cnt[note_idx]++;
            if (!playing) begin
                done_cyc = cyc;
                break;
            end
        end
        check("stb_count", stb_n, 8);
        for (int i = 1; i < 8; i++)
            check($sformatf("stb_time_idx%0d", i), stb_t[i], 23 * i);
        for (int i = 0; i < 8; i++)
            check($sformatf("en_len_idx%0d", i), en_cnt[i], exp_en_len[i]);
        check("done_cycle", done_cyc, 203);
        check("done_en", note_en, 0);

        // DONE with PLAY still high must not restart.
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (note_stb || playing) seen++;
        end
        check("done_no_restart", seen, 0);

        // One-cycle PLAY low, then high: strobe for entry 0 two cycles later.
        play = 1'b0;
        step();
        play = 1'b1;
        step();
        check("replay_no_stb_yet", note_stb, 0);
        step();
        check("replay_stb", note_stb, 1);
        check("replay_idx", note_idx, 0);

        // LOOP=1: entry 0 returns after the last entry's gap.
        loop = 1'b1;
        wait_stb(0, 300, n);
        check("loop_wrap_cycles", n, 204);
        check("loop_wrap_div", note_div, 190839);
        check("loop_playing", playing, 1);
        wait_stb(1, 100, n);
        check("loop_idx1_cycles", n, 23);

        // Stop in the middle of entry 2.
        wait_stb(2, 100, n);
        check("idx2_cycles", n, 23);
        for (int k = 0; k < 5; k++) step();
        play = 1'b0;
        step();
        check("stop_en", note_en, 0);
        check("stop_playing", playing, 0);
        check("stop_idx_hold", note_idx, 2);
        check("stop_div_hold", note_div, 151514);
        step();
        check("idle_no_stb", note_stb, 0);
        play = 1'b1;
        step();
        step();
        check("restart_stb", note_stb, 1);
        check("restart_idx", note_idx, 0);
        check("restart_div", note_div, 190839);

        // Reset pulse during the gap after entry 4.
        loop = 1'b0;
        wait_stb(4, 200, n);
        check("idx4_cycles", n, 92);
        for (int k = 0; k < 20; k++) step();
        check("gap4_en", note_en, 0);
        check("gap4_playing", playing, 1);
        check("gap4_div_hold", note_div, 127550);
        rst = 1'b1;
        step();
        check_reset_vals("midrst");
        rst = 1'b0;
        play = 1'b0;
        step();
        check("post_rst_idle", playing, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
